// File: rtl/axi4_master_pkg.sv
// Types and constants shared by the AXI4 command master blocks.
package axi4_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [2:0] axsize_f(input int dw);
    axsize_f = 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/axi4_cmd_master_if.sv
// Pin-level AXI4 bus between the command master and a slave.
interface axi4_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 4
);
  logic                    AWVALID, AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE, AWPROT;
  logic [1:0]              AWBURST;
  logic [ID_WIDTH-1:0]     AWID;
  logic [3:0]              AWREGION, AWCACHE, AWQOS;
  logic                    AWLOCK;
  logic [USER_WIDTH-1:0]   AWUSER;

  logic                    ARVALID, ARREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE, ARPROT;
  logic [1:0]              ARBURST;
  logic [ID_WIDTH-1:0]     ARID;
  logic [3:0]              ARREGION, ARCACHE, ARQOS;
  logic                    ARLOCK;
  logic [USER_WIDTH-1:0]   ARUSER;

  logic                    WVALID, WREADY, WLAST;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic [USER_WIDTH-1:0]   WUSER;

  logic                    BVALID, BREADY;
  logic [1:0]              BRESP;
  logic [ID_WIDTH-1:0]     BID;
  logic [USER_WIDTH-1:0]   BUSER;

  logic                    RVALID, RREADY, RLAST;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic [ID_WIDTH-1:0]     RID;
  logic [USER_WIDTH-1:0]   RUSER;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    output AWPROT, AWREGION, AWLOCK, AWCACHE, AWQOS, AWUSER,
    input  AWREADY,
    output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID,
    output ARPROT, ARREGION, ARLOCK, ARCACHE, ARQOS, ARUSER,
    input  ARREADY,
    output WVALID, WDATA, WSTRB, WLAST, WUSER,
    input  WREADY,
    input  BVALID, BRESP, BID, BUSER,
    output BREADY,
    input  RVALID, RDATA, RRESP, RLAST, RID, RUSER,
    output RREADY
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    input  AWPROT, AWREGION, AWLOCK, AWCACHE, AWQOS, AWUSER,
    output AWREADY,
    input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID,
    input  ARPROT, ARREGION, ARLOCK, ARCACHE, ARQOS, ARUSER,
    output ARREADY,
    input  WVALID, WDATA, WSTRB, WLAST, WUSER,
    output WREADY,
    output BVALID, BRESP, BID, BUSER,
    input  BREADY,
    output RVALID, RDATA, RRESP, RLAST, RID, RUSER,
    input  RREADY
  );

endinterface

// File: rtl/axi4_master_beat_cnt.sv
// Burst beat counter shared by the W and R phases.
module axi4_master_beat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       is_last
);

  logic [7:0] cnt_q, cnt_d;

  // Holds at len so a 256-beat burst never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != len))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign is_last = (cnt_q == len);

endmodule

// File: rtl/axi4_cmd_master.sv
// AXI4 master: one outstanding INCR burst from a command/data stream.
module axi4_cmd_master
  import axi4_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rsp_valid,
  output logic                    rsp_rnw,
  output logic [1:0]              rsp_resp,
  output logic [ID_WIDTH-1:0]     rsp_id,
  output logic                    protocol_err,
  axi4_cmd_master_if.master       axi
);

  localparam logic [2:0] SIZE = axsize_f(DATA_WIDTH);

  state_e                state_q, state_d;
  logic                  rnw_q, rnw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  cnt_clr, cnt_inc, is_last;
  logic                  unused_user;

  axi4_master_beat_cnt u_beat_cnt (
    .clk     (ACLK),
    .rst     (ARESET),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .len     (len_q),
    .is_last (is_last)
  );

  always_comb begin
    state_d     = state_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    resp_d      = resp_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    axi.AWVALID = 1'b0;
    axi.ARVALID = 1'b0;
    axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b0;
    axi.RREADY  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = ~ARESET;
        if (cmd_valid && !ARESET) begin
          rnw_d   = cmd_rnw;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          id_d    = cmd_id;
          resp_d  = RESP_OKAY;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
          state_d = cmd_rnw ? ST_AR : ST_AW;
        end
      end
      ST_AW: begin
        axi.AWVALID = 1'b1;
        if (axi.AWREADY) state_d = ST_W;
      end
      ST_W: begin
        axi.WVALID = wr_valid;
        wr_ready   = axi.WREADY;
        if (wr_valid && axi.WREADY) begin
          if (is_last) state_d = ST_B;
          else         cnt_inc = 1'b1;
        end
      end
      ST_B: begin
        axi.BREADY = 1'b1;
        if (axi.BVALID) begin
          resp_d      = axi.BRESP;
          err_d       = err_q | (axi.BID != id_q);
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_AR: begin
        axi.ARVALID = 1'b1;
        if (axi.ARREADY) state_d = ST_R;
      end
      ST_R: begin
        rd_valid   = axi.RVALID;
        axi.RREADY = rd_ready;
        if (axi.RVALID && rd_ready) begin
          if (axi.RID != id_q) err_d = 1'b1;
          if (resp_q == RESP_OKAY) resp_d = axi.RRESP;
          // Early or missing RLAST ends the burst at whichever comes first.
          if (axi.RLAST != is_last) err_d = 1'b1;
          if (axi.RLAST || is_last) begin
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      resp_q      <= RESP_OKAY;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      id_q        <= id_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign axi.AWADDR   = addr_q;
  assign axi.AWLEN    = len_q;
  assign axi.AWSIZE   = SIZE;
  assign axi.AWBURST  = BURST_INCR;
  assign axi.AWID     = id_q;
  assign axi.AWPROT   = '0;
  assign axi.AWREGION = '0;
  assign axi.AWLOCK   = 1'b0;
  assign axi.AWCACHE  = '0;
  assign axi.AWQOS    = '0;
  assign axi.AWUSER   = '0;

  assign axi.ARADDR   = addr_q;
  assign axi.ARLEN    = len_q;
  assign axi.ARSIZE   = SIZE;
  assign axi.ARBURST  = BURST_INCR;
  assign axi.ARID     = id_q;
  assign axi.ARPROT   = '0;
  assign axi.ARREGION = '0;
  assign axi.ARLOCK   = 1'b0;
  assign axi.ARCACHE  = '0;
  assign axi.ARQOS    = '0;
  assign axi.ARUSER   = '0;

  assign axi.WDATA = wr_data;
  assign axi.WSTRB = wr_strb;
  assign axi.WLAST = (state_q == ST_W) & is_last;
  assign axi.WUSER = '0;

  assign rd_data      = axi.RDATA;
  assign rd_last      = axi.RLAST;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rnw      = rnw_q;
  assign rsp_resp     = resp_q;
  assign rsp_id       = id_q;
  assign protocol_err = rsp_valid_q & err_q;
  assign unused_user  = ^{axi.BUSER, axi.RUSER};

endmodule

// File: tb/tb_axi4_cmd_master.sv
// Directed bench for axi4_cmd_master.
module tb_axi4_cmd_master;

  logic        clk = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        rsp_valid, rsp_rnw, protocol_err;
  logic [1:0]  rsp_resp;
  logic [3:0]  rsp_id;
  int          total = 0;
  int          bad = 0;

  axi4_cmd_master_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .ID_WIDTH(4), .USER_WIDTH(4)
  ) ifc ();

  axi4_cmd_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .ID_WIDTH(4), .USER_WIDTH(4)
  ) dut (
    .ACLK(clk), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_rnw(rsp_rnw),
    .rsp_resp(rsp_resp), .rsp_id(rsp_id),
    .protocol_err(protocol_err),
    .axi(ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic rnw, input logic [31:0] addr,
                       input logic [7:0] len, input logic [3:0] id);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_id    = id;
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp(input logic rnw, input logic [1:0] resp,
                            input logic [3:0] id, input logic err);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rnw", rsp_rnw, rnw);
    chk("rsp_resp", rsp_resp, resp);
    chk("rsp_id", rsp_id, id);
    chk("protocol_err", protocol_err, err);
    chk("rsp_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("err_pulse", protocol_err, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id, input int aw_wait,
                          input logic [3:0] bid, input logic [1:0] bresp,
                          input logic exp_err);
    issue(1'b0, addr, len, id);
    wr_valid   = 1'b1;
    wr_data    = 32'hA5000000;
    wr_strb    = 4'hF;
    ifc.WREADY = 1'b1;
    for (int i = 0; i <= aw_wait; i++) begin
      ifc.AWREADY = (i == aw_wait);
      @(negedge clk);
      chk("awvalid", ifc.AWVALID, 1);
      chk("awaddr", ifc.AWADDR, addr);
      chk("awlen", ifc.AWLEN, len);
      chk("awsize", ifc.AWSIZE, 2);
      chk("awburst", ifc.AWBURST, 1);
      chk("awid", ifc.AWID, id);
      chk("w_before_aw", {ifc.WVALID, wr_ready}, 0);
      @(posedge clk); #1;
    end
    ifc.AWREADY = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wr_data = 32'hA5000000 + i;
      wr_strb = 4'hF ^ 4'(i);
      @(negedge clk);
      chk("wvalid", ifc.WVALID, 1);
      chk("wr_ready", wr_ready, 1);
      chk("wdata", ifc.WDATA, 32'hA5000000 + i);
      chk("wstrb", ifc.WSTRB, 4'hF ^ 4'(i));
      chk("wlast", ifc.WLAST, (i == int'(len)));
      @(posedge clk); #1;
    end
    wr_valid    = 1'b0;
    ifc.WREADY  = 1'b0;
    ifc.BVALID  = 1'b1;
    ifc.BID     = bid;
    ifc.BRESP   = bresp;
    @(negedge clk);
    chk("bready", ifc.BREADY, 1);
    chk("wvalid_in_b", ifc.WVALID, 0);
    @(posedge clk); #1;
    ifc.BVALID = 1'b0;
    finish_rsp(1'b0, bresp, id, exp_err);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id, input logic [31:0] dbase,
                         input int last_at, input int err_beat,
                         input logic [1:0] err_resp, input bit toggle,
                         input logic exp_err, input logic [1:0] exp_resp);
    int beat = 0;
    int cyc = 0;
    bit hs;
    issue(1'b1, addr, len, id);
    @(negedge clk);
    chk("arvalid", ifc.ARVALID, 1);
    chk("araddr", ifc.ARADDR, addr);
    chk("arlen", ifc.ARLEN, len);
    chk("arsize", ifc.ARSIZE, 2);
    chk("arid", ifc.ARID, id);
    @(posedge clk); #1;
    while (beat <= last_at && cyc < 40) begin
      ifc.RVALID = 1'b1;
      ifc.RDATA  = dbase + beat;
      ifc.RLAST  = (beat == last_at);
      ifc.RRESP  = (beat == err_beat) ? err_resp : 2'b00;
      ifc.RID    = id;
      rd_ready   = toggle ? (cyc % 2 == 0) : 1'b1;
      hs         = rd_ready;
      @(negedge clk);
      chk("rready", ifc.RREADY, rd_ready);
      chk("rd_valid", rd_valid, 1);
      if (hs) begin
        chk("rd_data", rd_data, dbase + beat);
        chk("rd_last", rd_last, (beat == last_at));
      end
      @(posedge clk); #1;
      if (hs) beat++;
      cyc++;
    end
    if (cyc >= 40) chk("rd_timeout", cyc, 0);
    ifc.RVALID = 1'b0;
    ifc.RLAST  = 1'b0;
    rd_ready   = 1'b0;
    finish_rsp(1'b1, exp_resp, id, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=done");
    $fatal(1);
  end

  initial begin
    ARESET      = 1'b1;
    cmd_valid   = 1'b0;
    cmd_rnw     = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    cmd_id      = '0;
    wr_valid    = 1'b0;
    wr_data     = '0;
    wr_strb     = '0;
    rd_ready    = 1'b0;
    ifc.AWREADY = 1'b0;
    ifc.ARREADY = 1'b1;
    ifc.WREADY  = 1'b0;
    ifc.BVALID  = 1'b0;
    ifc.BRESP   = '0;
    ifc.BID     = '0;
    ifc.BUSER   = '0;
    ifc.RVALID  = 1'b0;
    ifc.RDATA   = '0;
    ifc.RRESP   = '0;
    ifc.RLAST   = 1'b0;
    ifc.RID     = '0;
    ifc.RUSER   = '0;

    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valids",
          {ifc.AWVALID, ifc.ARVALID, ifc.WVALID}, 0);
      chk("rst_readys", {ifc.BREADY, ifc.RREADY}, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp", {rsp_valid, protocol_err}, 0);
    end
    chk("aw_const", {ifc.AWPROT, ifc.AWREGION, ifc.AWLOCK,
        ifc.AWCACHE, ifc.AWQOS, ifc.AWUSER, ifc.WUSER}, 0);
    chk("ar_const", {ifc.ARPROT, ifc.ARREGION, ifc.ARLOCK,
        ifc.ARCACHE, ifc.ARQOS, ifc.ARUSER}, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ARESET    = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;

    do_write(32'h1000, 8'd3, 4'd5, 2, 4'd5, 2'b00, 1'b0);
    do_read(32'h20, 8'd0, 4'd3, 32'hDEADBEEF,
            0, -1, 2'b00, 1'b0, 1'b0, 2'b00);
    do_read(32'h40, 8'd3, 4'd7, 32'h11110000,
            3, 2, 2'b10, 1'b1, 1'b0, 2'b10);
    do_write(32'h2000, 8'd1, 4'd5, 0, 4'd6, 2'b00, 1'b1);
    do_read(32'h80, 8'd3, 4'd2, 32'h22220000,
            1, -1, 2'b00, 1'b0, 1'b1, 2'b00);
    do_write(32'h2400, 8'd0, 4'd9, 0, 4'd9, 2'b10, 1'b0);

    issue(1'b0, 32'h3000, 8'd3, 4'd1);
    ifc.AWREADY = 1'b1;
    @(negedge clk);
    chk("abort_awvalid", ifc.AWVALID, 1);
    @(posedge clk); #1;
    ifc.AWREADY = 1'b0;
    wr_valid    = 1'b1;
    ifc.WREADY  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_data = 32'hC0DE0000 + i;
      @(negedge clk);
      chk("abort_wvalid", ifc.WVALID, 1);
      @(posedge clk); #1;
    end
    ARESET = 1'b1;
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    ARESET = 1'b0;
    @(negedge clk);
    chk("abort_wvalid_drop", ifc.WVALID, 0);
    chk("abort_wr_ready", wr_ready, 0);
    chk("abort_no_rsp", rsp_valid, 0);
    chk("abort_idle", cmd_ready, 1);
    @(posedge clk); #1;
    wr_valid   = 1'b0;
    ifc.WREADY = 1'b0;
    @(negedge clk);
    chk("abort_no_rsp2", rsp_valid, 0);
    @(posedge clk); #1;

    do_read(32'h100, 8'd1, 4'd4, 32'h33330000,
            1, -1, 2'b00, 1'b0, 1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
